motor_ctr_ramp: RTL

- Parametrised successor to the direct-drive motor controller for the two-motor H-bridge.
- Converts one-hot direction commands (frente/tras/direita/esquerda) into PWM-gated H-bridge drive.
- Adds speed ramp-up and ramp-down, a dead-time on direction reversal, and an emergency stop on proximity alert when moving forward.
- Sits between the command/sonar logic and the motores pins of the cyclone top level.

---
 rtl/motor_ctr_ramp.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/motor_ctr_ramp.sv
// Two-motor H-bridge driver: one-hot direction commands to PWM-gated pins with duty ramping, reversal dead-time and forward-only emergency stop.
// Latency: motores registered 1 clk after state/duty/pwm_cnt; no backpressure, commands are sampled every cycle.
module motor_ctr_ramp #(
  parameter int PWM_BITS    = 8,
  parameter int PWM_DIV     = 195,
  parameter int RAMP_DIV    = 50000,
  parameter int RAMP_STEP   = 8,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frente,
  input  logic                tras,
  input  logic                direita,
  input  logic                esquerda,
  input  logic                alerta_proximidade,
  input  logic [PWM_BITS-1:0] vel_max,
  output logic [3:0]          motores,
  output logic                parado,
  output logic [PWM_BITS-1:0] db_duty,
  output logic [2:0]          db_estado
);

  typedef enum logic [2:0] {
    PARADO     = 3'd0,
    ACELERA    = 3'd1,
    CRUZEIRO   = 3'd2,
    DESACELERA = 3'd3,
    TROCA      = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE     = 3'd0,
    DIR_FRENTE   = 3'd1,
    DIR_TRAS     = 3'd2,
    DIR_DIREITA  = 3'd3,
    DIR_ESQUERDA = 3'd4
  } dir_t;

  localparam int PDW = $clog2(PWM_DIV + 1);
  localparam int RDW = $clog2(RAMP_DIV + 1);
  localparam int DDW = $clog2(DEAD_CYCLES + 1);

  localparam logic [PDW-1:0]    PDIV_LAST = PDW'(PWM_DIV - 1);
  localparam logic [RDW-1:0]    RDIV_LAST = RDW'(RAMP_DIV - 1);
  localparam logic [DDW-1:0]    DEAD_LAST = DDW'(DEAD_CYCLES - 1);
  localparam logic [PWM_BITS:0] STEP      = (PWM_BITS + 1)'(RAMP_STEP);

  state_t              state_q, state_d;
  dir_t                dir_q, dir_d;
  dir_t                cmd;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PDW-1:0]      pdiv_q, pdiv_d;
  logic [RDW-1:0]      rdiv_q, rdiv_d;
  logic [DDW-1:0]      dead_q, dead_d;
  logic [3:0]          motores_q, motores_d;

  logic                ramp_tick;
  logic                alert_stop;
  logic                pwm_on;
  logic [PWM_BITS:0]   duty_up;
  logic [PWM_BITS-1:0] up_sat;
  logic [PWM_BITS-1:0] dn_raw;
  logic [PWM_BITS-1:0] dn_tgt;
  logic [PWM_BITS-1:0] dn_sat;

  function automatic logic [3:0] dir_code(input dir_t d);
    case (d)
      DIR_FRENTE:   dir_code = 4'b1010;
      DIR_TRAS:     dir_code = 4'b0101;
      DIR_DIREITA:  dir_code = 4'b1001;
      DIR_ESQUERDA: dir_code = 4'b0110;
      default:      dir_code = 4'b0000;
    endcase
  endfunction

  // Anything other than exactly one command high is a stop request.
  always_comb begin
    cmd = DIR_NONE;
    case ({frente, tras, direita, esquerda})
      4'b1000: cmd = DIR_FRENTE;
      4'b0100: cmd = DIR_TRAS;
      4'b0010: cmd = DIR_DIREITA;
      4'b0001: cmd = DIR_ESQUERDA;
      default: cmd = DIR_NONE;
    endcase
  end

  always_comb begin
    pdiv_d    = (pdiv_q == PDIV_LAST) ? '0 : pdiv_q + PDW'(1);
    pwm_cnt_d = (pdiv_q == PDIV_LAST) ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
    rdiv_d    = (rdiv_q == RDIV_LAST) ? '0 : rdiv_q + RDW'(1);
  end

  assign ramp_tick  = (rdiv_q == RDIV_LAST);
  assign alert_stop = alerta_proximidade && (dir_q == DIR_FRENTE);
  assign pwm_on     = (pwm_cnt_q < duty_q);

  // Saturating ramp arithmetic; the down-ramp floor is vel_max only while the command still matches.
  always_comb begin
    duty_up = {1'b0, duty_q} + STEP;
    up_sat  = (duty_up > {1'b0, vel_max}) ? vel_max : duty_up[PWM_BITS-1:0];
    dn_raw  = ({1'b0, duty_q} > STEP) ? duty_q - STEP[PWM_BITS-1:0] : '0;
    dn_tgt  = (cmd == dir_q) ? vel_max : '0;
    dn_sat  = (dn_raw < dn_tgt) ? dn_tgt : dn_raw;
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (alert_stop) begin
      state_d = PARADO;
      duty_d  = '0;
      dir_d   = DIR_NONE;
      dead_d  = '0;
    end else begin
      case (state_q)
        PARADO: begin
          duty_d = '0;
          if (cmd != DIR_NONE && !(cmd == DIR_FRENTE && alerta_proximidade)) begin
            dir_d   = cmd;
            state_d = ACELERA;
          end
        end
        ACELERA: begin
          if (cmd != dir_q)            state_d = DESACELERA;
          else if (duty_q == vel_max)  state_d = CRUZEIRO;
          else if (duty_q > vel_max)   state_d = DESACELERA;
          else if (ramp_tick)          duty_d  = up_sat;
        end
        CRUZEIRO: begin
          if (cmd != dir_q)            state_d = DESACELERA;
          else if (vel_max > duty_q)   state_d = ACELERA;
          else if (vel_max < duty_q)   state_d = DESACELERA;
        end
        DESACELERA: begin
          if (cmd == dir_q) begin
            if (duty_q == vel_max)     state_d = CRUZEIRO;
            else if (duty_q < vel_max) state_d = ACELERA;
            else if (ramp_tick)        duty_d  = dn_sat;
          end else if (duty_q == '0) begin
            // Whatever command is present at zero duty decides reversal or stop.
            if (cmd == DIR_NONE) begin
              state_d = PARADO;
              dir_d   = DIR_NONE;
            end else begin
              state_d = TROCA;
              dead_d  = '0;
            end
          end else if (ramp_tick) begin
            duty_d = dn_sat;
          end
        end
        TROCA: begin
          duty_d = '0;
          if (dead_q == DEAD_LAST) begin
            dead_d = '0;
            if (cmd == DIR_NONE) begin
              state_d = PARADO;
              dir_d   = DIR_NONE;
            end else begin
              state_d = ACELERA;
              dir_d   = cmd;
            end
          end else begin
            dead_d = dead_q + DDW'(1);
          end
        end
        default: begin
          state_d = PARADO;
          duty_d  = '0;
          dir_d   = DIR_NONE;
          dead_d  = '0;
        end
      endcase
    end
  end

  // The alert bypasses the normal 1-clk pipeline so the bridge opens on the same edge as duty clears.
  always_comb begin
    motores_d = 4'b0000;
    if (!alert_stop && state_q != TROCA && pwm_on) motores_d = dir_code(dir_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PARADO;
      dir_q     <= DIR_NONE;
      duty_q    <= '0;
      pwm_cnt_q <= '0;
      pdiv_q    <= '0;
      rdiv_q    <= '0;
      dead_q    <= '0;
      motores_q <= 4'b0000;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_d;
      pdiv_q    <= pdiv_d;
      rdiv_q    <= rdiv_d;
      dead_q    <= dead_d;
      motores_q <= motores_d;
    end
  end

  assign motores   = motores_q;
  assign parado    = (state_q == PARADO) && (duty_q == '0);
  assign db_duty   = duty_q;
  assign db_estado = state_q;

endmodule
